id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/hazard_detect.sv | 25 ++
 rtl/id_ex_pipe.sv | 117 +++++++++++
 tb/tb_id_ex_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALUOp encodings, ID/EX control and payload records.
package cpu_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_VEC    = 7'b1010111;

  typedef enum logic [1:0] {
    ALU_MEM    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } aluop_e;

  // Decoder control word, MSB first; the bit offsets below match the struct layout.
  typedef struct packed {
    logic   mem_to_reg;
    logic   mem_read;
    logic   mem_write;
    logic   reg_write;
    aluop_e alu_op;
    logic   alu_src;
    logic   imm_sel;
    logic   vec;
  } ctl_t;

  localparam int CTL_W        = 9;
  localparam int CTL_MEMTOREG = 8;
  localparam int CTL_MEMREAD  = 7;
  localparam int CTL_MEMWRITE = 6;
  localparam int CTL_REGWRITE = 5;
  localparam int CTL_ALUOP_HI = 4;
  localparam int CTL_ALUOP_LO = 3;
  localparam int CTL_ALUSRC   = 2;
  localparam int CTL_IMMSEL   = 1;
  localparam int CTL_VEC      = 0;

  // Operand payload carried unmodified from decode into execute.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } payload_t;

  // Vector-immediate forms reuse the rs1 field for the immediate, so it is not a register read.
  function automatic logic is_vec_imm(ctl_t c);
    return c.vec & c.imm_sel;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the instruction in EX is a load whose destination the decode-stage
// instruction is about to read.
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_valid_i,
  input  logic       id_vec_imm_i,
  input  logic       id_alu_src_i,
  input  logic       id_mem_write_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       hazard_o
);

  logic rs1_hit, rs2_hit;

  // rs2 is only a real source when the ALU takes it or a store writes it out; x0 never stalls.
  always_comb begin
    rs1_hit  = (ex_rd_i == id_rs1_i) & ~id_vec_imm_i;
    rs2_hit  = (ex_rd_i == id_rs2_i) & (~id_alu_src_i | id_mem_write_i);
    hazard_o = id_valid_i & ex_valid_i & ex_mem_read_i & (ex_rd_i != 5'd0) & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, EX back-pressure hold and flush.
module id_ex_pipe
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [8:0]  ctl_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic        ex_ready_i,
  input  logic        flush_i,
  output logic [8:0]  ctl_o,
  output logic [31:0] pc_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  output logic [4:0]  rd_addr_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic        valid_o,
  output logic        stall_o,
  output logic [15:0] perf_bubbles_o
);

  ctl_t     ctl_in, ctl_q, ctl_d;
  payload_t data_in, data_q, data_d;
  logic     valid_q, valid_d;
  logic [15:0] perf_q, perf_d;
  logic     stall;

  assign ctl_in  = ctl_t'(ctl_i);
  assign data_in = '{pc: pc_i, rs1_data: rs1_data_i, rs2_data: rs2_data_i, imm: imm_i,
                     rs1_addr: rs1_addr_i, rs2_addr: rs2_addr_i, rd_addr: rd_addr_i,
                     funct3: funct3_i, funct7: funct7_i};

  hazard_detect u_hazard (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (ctl_q.mem_read),
    .ex_rd_i        (data_q.rd_addr),
    .id_valid_i     (valid_i),
    .id_vec_imm_i   (is_vec_imm(ctl_in)),
    .id_alu_src_i   (ctl_in.alu_src),
    .id_mem_write_i (ctl_in.mem_write),
    .id_rs1_i       (rs1_addr_i),
    .id_rs2_i       (rs2_addr_i),
    .hazard_o       (stall)
  );

  assign stall_o = stall;
  assign ready_o = ex_ready_i & ~stall & ~flush_i;

  // Next state: flush > hold > bubble > load > drain. Going empty clears control but leaves
  // stale operand data in place, since nothing downstream looks at it without valid.
  always_comb begin
    valid_d = valid_q;
    ctl_d   = ctl_q;
    data_d  = data_q;
    perf_d  = perf_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctl_d   = '0;
    end else if (!ex_ready_i) begin
      // hold: EX is busy, keep everything
    end else if (stall) begin
      valid_d = 1'b0;
      ctl_d   = '0;
      if (perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
    end else if (valid_i) begin
      valid_d = 1'b1;
      ctl_d   = ctl_in;
      data_d  = data_in;
    end else begin
      valid_d = 1'b0;
      ctl_d   = '0;
    end
  end

  // Pipeline register with asynchronous clear of every output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ctl_q   <= '0;
      data_q  <= '0;
      perf_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctl_q   <= ctl_d;
      data_q  <= data_d;
      perf_q  <= perf_d;
    end
  end

  assign valid_o        = valid_q;
  assign ctl_o          = ctl_q;
  assign pc_o           = data_q.pc;
  assign rs1_data_o     = data_q.rs1_data;
  assign rs2_data_o     = data_q.rs2_data;
  assign imm_o          = data_q.imm;
  assign rs1_addr_o     = data_q.rs1_addr;
  assign rs2_addr_o     = data_q.rs2_addr;
  assign rd_addr_o      = data_q.rd_addr;
  assign funct3_o       = data_q.funct3;
  assign funct7_o       = data_q.funct7;
  assign perf_bubbles_o = perf_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: table of per-cycle vectors with a scoreboard of accepted instructions,
// then hand-written reset and counter-saturation sequences.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, ex_ready_i, flush_i, valid_o, stall_o;
  logic [8:0]  ctl_i, ctl_o;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i, pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [2:0]  funct3_i, funct3_o;
  logic [6:0]  funct7_i, funct7_o;
  logic [15:0] perf_bubbles_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_pipe dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .ctl_i(ctl_i),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .funct3_i(funct3_i), .funct7_i(funct7_i), .ex_ready_i(ex_ready_i), .flush_i(flush_i),
    .ctl_o(ctl_o), .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o), .valid_o(valid_o), .stall_o(stall_o),
    .perf_bubbles_o(perf_bubbles_o)
  );

  // Control words: {MemtoReg,MemRead,MemWrite,RegWrite,ALUOp[1:0],ALUSrc,immSelect,vec}
  localparam logic [8:0] C_ADDI = 9'b000111100;
  localparam logic [8:0] C_ADD  = 9'b000110000;
  localparam logic [8:0] C_LW   = 9'b110100100;
  localparam logic [8:0] C_SW   = 9'b001000100;
  localparam logic [8:0] C_VV   = 9'b000110001;
  localparam logic [8:0] C_VI   = 9'b000110111;

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } inst_t;

  typedef enum {E_LOAD, E_EMPTY, E_HOLD} exp_e;

  typedef struct {
    inst_t       in;
    logic        vi, exr, fl;
    logic        stall, rdy;
    exp_e        ex;
    logic [15:0] bub;
  } row_t;

  row_t  tbl[$];
  inst_t sbq[$];
  inst_t held;

  function automatic inst_t mk(logic [8:0] c, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                               logic [31:0] pc, logic [31:0] imm);
    inst_t x;
    x.ctl = c; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2; x.pc = pc; x.imm = imm;
    x.rs1d = {pc[15:0], 16'h1111};
    x.rs2d = ~pc;
    x.f3 = pc[4:2];
    x.f7 = pc[10:4];
    return x;
  endfunction

  function automatic row_t r(inst_t x, logic vi, logic exr, logic fl, logic st, logic rdy,
                             exp_e ex, logic [15:0] bub);
    row_t t;
    t.in = x; t.vi = vi; t.exr = exr; t.fl = fl; t.stall = st; t.rdy = rdy; t.ex = ex; t.bub = bub;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(inst_t x, logic vi, logic exr, logic fl);
    valid_i = vi; ex_ready_i = exr; flush_i = fl;
    ctl_i = x.ctl; pc_i = x.pc; rs1_data_i = x.rs1d; rs2_data_i = x.rs2d; imm_i = x.imm;
    rs1_addr_i = x.rs1; rs2_addr_i = x.rs2; rd_addr_i = x.rd; funct3_i = x.f3; funct7_i = x.f7;
  endtask

  task automatic chk_out(string tag, inst_t e);
    chk({tag, " valid"}, 32'(valid_o), 32'd1);
    chk({tag, " ctl"}, 32'(ctl_o), 32'(e.ctl));
    chk({tag, " pc"}, pc_o, e.pc);
    chk({tag, " rs1d"}, rs1_data_o, e.rs1d);
    chk({tag, " rs2d"}, rs2_data_o, e.rs2d);
    chk({tag, " imm"}, imm_o, e.imm);
    chk({tag, " addrs"}, {17'd0, rs1_addr_o, rs2_addr_o, rd_addr_o}, {17'd0, e.rs1, e.rs2, e.rd});
    chk({tag, " funct"}, {22'd0, funct3_o, funct7_o}, {22'd0, e.f3, e.f7});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    inst_t nop, x, a;

    // ---- reset state ----
    nop = mk(9'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    rst = 1'b1;
    drive(nop, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst valid", 32'(valid_o), 32'd0);
    chk("rst ctl", 32'(ctl_o), 32'd0);
    chk("rst pc", pc_o, 32'd0);
    chk("rst data", rs1_data_o | rs2_data_o | imm_o, 32'd0);
    chk("rst perf", 32'(perf_bubbles_o), 32'd0);
    rst = 1'b0;

    // ---- vector table ----
    tbl.push_back(r(mk(C_ADDI, 1, 0, 0, 32'h100, 32'd5), 1, 1, 0, 0, 1, E_LOAD, 0));   // addi x1
    tbl.push_back(r(mk(C_ADD, 2, 1, 3, 32'h104, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 0));    // add x2,x1,x3
    tbl.push_back(r(mk(C_ADD, 0, 0, 0, 32'h0, 32'd0), 0, 1, 0, 0, 1, E_EMPTY, 0));     // idle
    tbl.push_back(r(mk(C_LW, 5, 2, 0, 32'h108, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 0));     // lw x5
    tbl.push_back(r(mk(C_ADD, 6, 5, 7, 32'h10C, 32'd0), 1, 1, 0, 1, 0, E_EMPTY, 1));   // load-use
    tbl.push_back(r(mk(C_ADD, 6, 5, 7, 32'h10C, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 1));    // add captured
    tbl.push_back(r(mk(C_LW, 0, 2, 0, 32'h110, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 1));     // lw x0
    tbl.push_back(r(mk(C_ADD, 6, 0, 7, 32'h114, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 1));    // x0 exempt
    tbl.push_back(r(mk(C_VV, 8, 1, 2, 32'h118, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 1));     // vector op
    for (int i = 0; i < 3; i++)
      tbl.push_back(r(mk(C_ADDI, 9, 8, 0, 32'h11C, 32'd7), 1, 0, 0, 0, 0, E_HOLD, 1)); // held 3 cycles
    tbl.push_back(r(mk(C_ADDI, 9, 8, 0, 32'h11C, 32'd7), 1, 1, 0, 0, 1, E_LOAD, 1));   // released
    tbl.push_back(r(mk(C_LW, 5, 9, 0, 32'h120, 32'd4), 1, 1, 0, 0, 1, E_LOAD, 1));
    tbl.push_back(r(mk(C_ADD, 6, 5, 7, 32'h124, 32'd0), 1, 0, 1, 1, 0, E_EMPTY, 1));   // flush wins
    tbl.push_back(r(mk(C_LW, 5, 2, 0, 32'h128, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 1));
    tbl.push_back(r(mk(C_ADD, 6, 5, 7, 32'h12C, 32'd0), 0, 1, 0, 0, 1, E_EMPTY, 1));   // gated by valid_i
    tbl.push_back(r(mk(C_LW, 5, 2, 0, 32'h130, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 1));
    tbl.push_back(r(mk(C_VI, 10, 5, 3, 32'h134, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 1));    // vec-imm rs1 ignored
    tbl.push_back(r(mk(C_LW, 8, 2, 0, 32'h138, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 1));
    tbl.push_back(r(mk(C_SW, 0, 2, 8, 32'h13C, 32'd8), 1, 1, 0, 1, 0, E_EMPTY, 2));    // store data hazard
    tbl.push_back(r(mk(C_SW, 0, 2, 8, 32'h13C, 32'd8), 1, 1, 0, 0, 1, E_LOAD, 2));
    tbl.push_back(r(mk(C_LW, 7, 2, 0, 32'h140, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 2));
    tbl.push_back(r(mk(C_ADD, 3, 1, 7, 32'h144, 32'd0), 1, 1, 0, 1, 0, E_EMPTY, 3));   // rs2 hazard
    tbl.push_back(r(mk(C_ADD, 3, 1, 7, 32'h144, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 3));
    tbl.push_back(r(mk(C_LW, 5, 2, 0, 32'h148, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 3));
    tbl.push_back(r(mk(C_ADD, 6, 5, 7, 32'h14C, 32'd0), 1, 0, 0, 1, 0, E_HOLD, 3));    // stall under hold: no bubble
    tbl.push_back(r(mk(C_ADD, 6, 5, 7, 32'h14C, 32'd0), 1, 1, 0, 1, 0, E_EMPTY, 4));
    tbl.push_back(r(mk(C_ADD, 6, 5, 7, 32'h14C, 32'd0), 1, 1, 0, 0, 1, E_LOAD, 4));

    @(negedge clk);
    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("row%0d", i);
      drive(tbl[i].in, tbl[i].vi, tbl[i].exr, tbl[i].fl);
      #1;
      chk({tag, " stall"}, 32'(stall_o), 32'(tbl[i].stall));
      chk({tag, " ready"}, 32'(ready_o), 32'(tbl[i].rdy));
      if (tbl[i].vi && tbl[i].rdy) sbq.push_back(tbl[i].in);
      @(posedge clk); #1;
      case (tbl[i].ex)
        E_LOAD: begin
          if (sbq.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
          end else begin
            held = sbq.pop_front();
            chk_out(tag, held);
          end
        end
        E_HOLD: chk_out({tag, " hold"}, held);
        default: begin
          chk({tag, " valid"}, 32'(valid_o), 32'd0);
          chk({tag, " ctl"}, 32'(ctl_o), 32'd0);
        end
      endcase
      chk({tag, " perf"}, 32'(perf_bubbles_o), 32'(tbl[i].bub));
      @(negedge clk);
    end
    chk("scoreboard drained", 32'(sbq.size()), 32'd0);

    // ---- async reset between edges while FULL and stalling ----
    x = mk(C_LW, 5, 2, 0, 32'h200, 32'd0);
    drive(x, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("arst pre valid", 32'(valid_o), 32'd1);
    @(negedge clk);
    a = mk(C_ADD, 6, 5, 7, 32'h204, 32'd0);
    drive(a, 1'b1, 1'b1, 1'b0);
    #1;
    chk("arst pre stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst valid", 32'(valid_o), 32'd0);
    chk("arst ctl", 32'(ctl_o), 32'd0);
    chk("arst pc", pc_o, 32'd0);
    chk("arst rd", 32'(rd_addr_o), 32'd0);
    chk("arst perf", 32'(perf_bubbles_o), 32'd0);
    chk("arst stall", 32'(stall_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_out("post-rst load", a);
    chk("post-rst perf", 32'(perf_bubbles_o), 32'd0);

    // ---- saturation: preload near the top, then bubbles ----
    @(negedge clk);
    drive(x, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    force dut.perf_q = 16'hFFFE;
    #1 release dut.perf_q;
    drive(a, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("sat step to FFFF", 32'(perf_bubbles_o), 32'h0000FFFF);
    chk("sat bubble valid", 32'(valid_o), 32'd0);
    @(negedge clk);
    drive(x, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(a, 1'b1, 1'b1, 1'b0);
    #1;
    chk("sat stall", 32'(stall_o), 32'd1);
    @(posedge clk); #1;
    chk("sat hold at FFFF", 32'(perf_bubbles_o), 32'h0000FFFF);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
